// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// FSM encoding and default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum1bcc.sv
// Single-bit full adder used by the serial adder.
// out is the sum bit, z the carry out.
module sum1bcc (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic out,
  output logic z
);

  assign out = x ^ y ^ c;
  assign z   = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, one bit per clock, LSB first.
// Start/done handshake; result held until the next accepted start.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_out;
  logic             fa_z;

  sum1bcc u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .c  (carry),
    .out(fa_out),
    .z  (fa_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum   <= {fa_out, sum[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_z;
          // last bit: latch the final carry and raise done next cycle
          if (cnt == CW'(WIDTH - 1)) begin
            cout  <= fa_z;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected
// {cout,sum}, a done-driven monitor pops and compares.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W), .CW(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      logic [W:0] e;
      ndone++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got %0d want none",
                 {cout, sum});
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          bad++;
          $display("FAIL result: got %0d want %0d", {cout, sum}, e);
        end
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input bit full);
    logic [W:0] e;
    int k;
    e = model(ia, ib, ic);
    @(negedge clk);
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    cin = ~ic;
    if (full) chk("busy_after_start", int'(busy), 1);
    wait_done(k);
    if (full) chk("latency", k, W + 1);
    @(negedge clk);
    if (full) begin
      chk("done_pulse", int'(done), 0);
      chk("busy_idle", int'(busy), 0);
      chk("held", int'({cout, sum}), int'(e));
    end
  endtask

  initial begin
    int k;
    int base;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", int'({busy, done, cout, sum}), 0);
      @(negedge clk);
    end

    do_op(4'd3, 4'd5, 1'b0, 1'b1);
    do_op(4'd15, 4'd1, 1'b0, 1'b1);
    do_op(4'd15, 4'd15, 1'b1, 1'b1);
    do_op(4'd0, 4'd0, 1'b1, 1'b1);

    // start held high: second capture sees the changed operands
    @(negedge clk);
    a = 4'd6;
    b = 4'd7;
    cin = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(4'd6, 4'd7, 1'b0));
    exp_q.push_back(model(4'd1, 4'd1, 1'b0));
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    wait_done(k);
    chk("cont_latency", k, W + 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    chk("cont_period", k, W + 2);
    start = 1'b0;
    @(negedge clk);
    chk("cont_held", int'({cout, sum}), 2);
    chk("cont_busy", int'(busy), 0);

    // reset mid-RUN abandons the operation
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", int'({busy, done, cout, sum}), 0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_nodone", int'({busy, done}), 0);
    end
    do_op(4'd2, 4'd2, 1'b0, 1'b1);

    base = ndone;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          do_op(W'(x), W'(y), c[0], 1'b0);
    chk("sweep_done_count", ndone - base, 512);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
